// File: rtl/uart_rx_os8.sv
// 8x-oversampled 8N1 UART receiver, LSB first. rx is synchronized, each bit is
// sampled at tick 3 of 8, and strobes are registered one clk after the stop sample.
module uart_rx_os8 #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done,
    output logic                 o_rx_busy,
    output logic                 o_frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] SAMPLE_PT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_n;
    logic                   rx_m, rx_s;
    logic [CW-1:0]          b_cnt, b_cnt_n;
    logic [BW-1:0]          bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [DATA_BITS-1:0]   dout_n;
    logic                   done_n, ferr_n, busy_n;

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= WAIT_IDLE;
            b_cnt       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_dout      <= '0;
            o_rx_done   <= 1'b0;
            o_rx_busy   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            rx_m        <= rx;
            rx_s        <= rx_m;
            state       <= state_n;
            b_cnt       <= b_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            o_dout      <= dout_n;
            o_rx_done   <= done_n;
            o_rx_busy   <= busy_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_n   = state;
        b_cnt_n   = b_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        dout_n    = o_dout;
        done_n    = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            WAIT_IDLE: begin
                b_cnt_n   = '0;
                bit_cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            IDLE: begin
                b_cnt_n   = '0;
                bit_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (baud_tick) begin
                    if (b_cnt == SAMPLE_PT && rx_s) begin
                        b_cnt_n = '0;
                        state_n = IDLE;
                    end else if (b_cnt == LAST_TICK) begin
                        b_cnt_n = '0;
                        state_n = DATA;
                    end else begin
                        b_cnt_n = b_cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    b_cnt_n = b_cnt + CW'(1);
                    if (b_cnt == SAMPLE_PT) shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (b_cnt == LAST_TICK) begin
                        b_cnt_n = '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n = '0;
                            state_n   = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught immediately.
                if (baud_tick) begin
                    b_cnt_n = b_cnt + CW'(1);
                    if (b_cnt == SAMPLE_PT) begin
                        b_cnt_n = '0;
                        if (rx_s) begin
                            dout_n  = shreg;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                    end
                end
            end
            default: state_n = WAIT_IDLE;
        endcase

        busy_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    end

endmodule

// File: tb/tb_uart_rx_os8.sv
// Randomized bench for uart_rx_os8: a bench-side transmitter drives frames and a
// queue of expected bytes / frame errors is compared against strobes seen on the outputs.
module tb_uart_rx_os8;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] o_dout;
    logic       o_rx_done, o_rx_busy, o_frame_err;

    int total = 0;
    int bad   = 0;

    uart_rx_os8 dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .o_dout     (o_dout),
        .o_rx_done  (o_rx_done),
        .o_rx_busy  (o_rx_busy),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    // Shortened tick divider keeps the run short; the bit period is still 8 ticks.
    int tick_cnt = 0;
    always @(posedge clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt  <= 0;
            baud_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 1;
            baud_tick <= 1'b0;
        end
    end

    // Output monitor: records observations only; the test tasks judge them.
    logic [7:0] got_q[$];
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    int         wide_cnt    = 0;
    int         glitch_cnt  = 0;
    logic       prev_done   = 1'b0;
    logic       prev_ferr   = 1'b0;
    logic       prev_rst    = 1'b1;
    logic [7:0] prev_dout   = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_rx_done) got_q.push_back(o_dout);
            if (o_frame_err) ferr_cnt++;
            if (o_rx_done && o_frame_err) overlap_cnt++;
            if ((o_rx_done && prev_done) || (o_frame_err && prev_ferr)) wide_cnt++;
            if (!prev_rst && !o_rx_done && (o_dout !== prev_dout)) glitch_cnt++;
        end
        prev_done = o_rx_done;
        prev_ferr = o_frame_err;
        prev_rst  = rst;
        prev_dout = o_dout;
    end

    // Reference model: what a correct receiver must have reported so far.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int start_ticks);
        drive_bit(1'b0, start_ticks);
        for (int i = 0; i < 8; i++) drive_bit(data[i], 8);
        drive_bit(stop_bit, 8);
        if (stop_bit) exp_q.push_back(data);
        else exp_ferr++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_dout, o_rx_done, o_rx_busy, o_frame_err} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=000", {o_dout, o_rx_done, o_rx_busy, o_frame_err});
        end
        rst = 1'b0;
        wait_ticks(4);
        total++;
        if ({o_dout, o_rx_busy} !== 9'd0) begin
            bad++;
            $display("FAIL post_reset_idle got=%h want=000", {o_dout, o_rx_busy});
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'h55;
        total++;
        if (o_rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_before got=%b want=0", o_rx_busy);
        end
        drive_bit(1'b0, 8);
        drive_bit(d[0], 8);
        total++;
        if (o_rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_during got=%b want=1", o_rx_busy);
        end
        for (int i = 1; i < 8; i++) drive_bit(d[i], 8);
        drive_bit(1'b1, 8);
        exp_q.push_back(d);
        total++;
        if (o_rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after got=%b want=0", o_rx_busy);
        end
        total++;
        if (o_dout !== 8'h55) begin
            bad++;
            $display("FAIL single_dout got=%h want=55", o_dout);
        end
        total++;
        if (got_q.size() !== exp_q.size() || ferr_cnt !== exp_ferr) begin
            bad++;
            $display("FAIL single_strobes got done=%0d ferr=%0d want done=%0d ferr=%0d",
                     got_q.size(), ferr_cnt, exp_q.size(), exp_ferr);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = exp_q.size();
        send_frame(8'hA3, 1'b1, 8);
        send_frame(8'h0F, 1'b1, 8);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int k = base; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL b2b_byte%0d got=%h want=%h", k - base,
                         (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
    endtask

    task automatic test_glitch();
        int n_done;
        n_done = got_q.size();
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 20);
        total++;
        if (got_q.size() !== n_done || ferr_cnt !== exp_ferr) begin
            bad++;
            $display("FAIL glitch_strobes got done=%0d ferr=%0d want done=%0d ferr=%0d",
                     got_q.size(), ferr_cnt, n_done, exp_ferr);
        end
        total++;
        if (o_rx_busy !== 1'b0 || o_dout !== exp_q[$]) begin
            bad++;
            $display("FAIL glitch_state got busy=%b dout=%h want busy=0 dout=%h",
                     o_rx_busy, o_dout, exp_q[$]);
        end
    endtask

    task automatic test_break();
        send_frame(8'h12, 1'b1, 8);
        send_frame(8'hFF, 1'b0, 8);
        drive_bit(1'b0, 20);
        total++;
        if (ferr_cnt !== exp_ferr) begin
            bad++;
            $display("FAIL break_ferr_count got=%0d want=%0d", ferr_cnt, exp_ferr);
        end
        total++;
        if (o_dout !== 8'h12 || o_rx_busy !== 1'b0 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL break_hold got dout=%h busy=%b done=%0d want dout=12 busy=0 done=%0d",
                     o_dout, o_rx_busy, got_q.size(), exp_q.size());
        end
        drive_bit(1'b1, 8);
        send_frame(8'h3C, 1'b1, 8);
        total++;
        if (o_dout !== 8'h3C || got_q.size() !== exp_q.size() || got_q[$] !== 8'h3C) begin
            bad++;
            $display("FAIL break_recover got dout=%h done=%0d want dout=3c done=%0d",
                     o_dout, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'h81;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
        rst = 1'b1;
        #1;
        total++;
        if ({o_dout, o_rx_done, o_rx_busy, o_frame_err} !== 11'd0) begin
            bad++;
            $display("FAIL midrst_outputs got=%h want=000", {o_dout, o_rx_done, o_rx_busy, o_frame_err});
        end
        rx = 1'b1;
        wait_ticks(4);
        rst = 1'b0;
        wait_ticks(4);
        total++;
        if (got_q.size() !== exp_q.size() || o_rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_partial got done=%0d busy=%b want done=%0d busy=0",
                     got_q.size(), o_rx_busy, exp_q.size());
        end
        send_frame(d, 1'b1, 8);
        total++;
        if (o_dout !== 8'h81 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL midrst_resend got dout=%h done=%0d want dout=81 done=%0d",
                     o_dout, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_loopback();
        int         base;
        logic [7:0] fixed[3];
        fixed = '{8'h00, 8'hC5, 8'hFF};
        base = exp_q.size();
        for (int i = 0; i < 3; i++) send_frame(fixed[i], 1'b1, 8);
        for (int i = 0; i < 16; i++) begin
            wait_ticks($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(8, 9));
        end
        total++;
        if (got_q.size() !== exp_q.size() || ferr_cnt !== exp_ferr) begin
            bad++;
            $display("FAIL loop_count got done=%0d ferr=%0d want done=%0d ferr=%0d",
                     got_q.size(), ferr_cnt, exp_q.size(), exp_ferr);
        end
        for (int k = base; k < exp_q.size(); k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL loop_byte%0d got=%h want=%h", k - base,
                         (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
    endtask

    task automatic test_strobe_rules();
        total++;
        if (overlap_cnt !== 0) begin
            bad++;
            $display("FAIL strobe_overlap got=%0d want=0", overlap_cnt);
        end
        total++;
        if (wide_cnt !== 0) begin
            bad++;
            $display("FAIL strobe_width got=%0d want=0", wide_cnt);
        end
        total++;
        if (glitch_cnt !== 0) begin
            bad++;
            $display("FAIL dout_change_without_done got=%0d want=0", glitch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_mid_reset();
        test_loopback();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
